// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch stage: PC register, next-PC select, IF/ID pipeline register
//
// Build option: define FETCH_ALIGN_CHECK_EN to trap misaligned redirect targets
// (sticky addr_err, fetch frozen). When it is undefined, the low two target bits are
// cleared before the target is loaded and addr_err is tied low.
//
// Ports:
//   clk            in   clock, all state updates on the rising edge
//   rst            in   synchronous active-low reset
//   stall          in   hold PC and IF/ID (hazard unit)
//   flush          in   squash the instruction entering IF/ID
//   branch_taken   in   redirect to branch_target (from EX), wins over jump
//   branch_target  in   [31:0] branch destination byte address
//   jump           in   redirect to jump_target (from ID)
//   jump_target    in   [31:0] jump destination byte address
//   imem_rdata     in   [31:0] instruction word for imem_addr (combinational memory)
//   pc             out  [31:0] current fetch PC
//   imem_addr      out  [31:0] instruction memory address, same as pc
//   if_id_instr    out  [31:0] registered instruction to decode
//   if_id_pc4      out  [31:0] registered PC+4 of that instruction
//   if_id_valid    out  IF/ID holds a live instruction
//   addr_err       out  sticky misaligned-target flag

module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc,
    output logic [31:0] imem_addr,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc4,
    output logic        if_id_valid,
    output logic        addr_err
);

    logic [31:0] pc_q, pc_d;
    logic [31:0] if_id_instr_q, if_id_instr_d;
    logic [31:0] if_id_pc4_q, if_id_pc4_d;
    logic        if_id_valid_q, if_id_valid_d;

    logic [31:0] pc_plus4;
    logic        redirect;
    logic [31:0] redirect_target;

    // Natural 32-bit wrap gives 0xFFFF_FFFC + 4 = 0.
    assign pc_plus4        = pc_q + 32'd4;
    assign redirect        = branch_taken | jump;
    assign redirect_target = branch_taken ? branch_target : jump_target;

`ifdef FETCH_ALIGN_CHECK_EN
    logic addr_err_q, addr_err_d;
    logic target_misaligned;

    assign target_misaligned = redirect && (redirect_target[1:0] != 2'b00);
    assign addr_err          = addr_err_q;
`else
    assign addr_err = 1'b0;
`endif

    always_comb begin
        pc_d          = pc_q;
        if_id_instr_d = if_id_instr_q;
        if_id_pc4_d   = if_id_pc4_q;
        if_id_valid_d = if_id_valid_q;
`ifdef FETCH_ALIGN_CHECK_EN
        addr_err_d    = addr_err_q;
        // Once trapped, fetch stays frozen with a bubble in IF/ID until reset.
        if (addr_err_q || target_misaligned) begin
            addr_err_d    = 1'b1;
            if_id_instr_d = 32'h0;
            if_id_pc4_d   = 32'h0;
            if_id_valid_d = 1'b0;
        end else
`endif
        if (redirect) begin
`ifdef FETCH_ALIGN_CHECK_EN
            pc_d = redirect_target;
`else
            pc_d = redirect_target & ~32'd3;
`endif
            if_id_instr_d = 32'h0;
            if_id_pc4_d   = 32'h0;
            if_id_valid_d = 1'b0;
        end else if (stall) begin
            // PC holds; a concurrent flush still turns IF/ID into a bubble.
            if (flush) begin
                if_id_instr_d = 32'h0;
                if_id_pc4_d   = 32'h0;
                if_id_valid_d = 1'b0;
            end
        end else begin
            pc_d = pc_plus4;
            if (flush) begin
                if_id_instr_d = 32'h0;
                if_id_pc4_d   = 32'h0;
                if_id_valid_d = 1'b0;
            end else begin
                if_id_instr_d = imem_rdata;
                if_id_pc4_d   = pc_plus4;
                if_id_valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            pc_q          <= RESET_PC;
            if_id_instr_q <= 32'h0;
            if_id_pc4_q   <= 32'h0;
            if_id_valid_q <= 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
            addr_err_q    <= 1'b0;
`endif
        end else begin
            pc_q          <= pc_d;
            if_id_instr_q <= if_id_instr_d;
            if_id_pc4_q   <= if_id_pc4_d;
            if_id_valid_q <= if_id_valid_d;
`ifdef FETCH_ALIGN_CHECK_EN
            addr_err_q    <= addr_err_d;
`endif
        end
    end

    assign pc          = pc_q;
    assign imem_addr   = pc_q;
    assign if_id_instr = if_id_instr_q;
    assign if_id_pc4   = if_id_pc4_q;
    assign if_id_valid = if_id_valid_q;

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed self-checking bench for fetch_stage

module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        flush;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jump;
    logic [31:0] jump_target;
    logic [31:0] imem_rdata;
    logic [31:0] pc;
    logic [31:0] imem_addr;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc4;
    logic        if_id_valid;
    logic        addr_err;

    int vectors   = 0;
    int miscompares = 0;

    localparam logic [31:0] IMEM_KEY = 32'h1357_0000;

    fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .flush         (flush),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .jump          (jump),
        .jump_target   (jump_target),
        .imem_rdata    (imem_rdata),
        .pc            (pc),
        .imem_addr     (imem_addr),
        .if_id_instr   (if_id_instr),
        .if_id_pc4     (if_id_pc4),
        .if_id_valid   (if_id_valid),
        .addr_err      (addr_err)
    );

    always #5 clk = ~clk;

    // Instruction memory: each word is its address XOR a fixed key.
    assign imem_rdata = imem_addr ^ IMEM_KEY;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [31:0] e_pc, input logic [31:0] e_instr,
                             input logic [31:0] e_pc4, input logic e_valid, input logic e_err);
        check({tag, ".pc"}, pc, e_pc);
        check({tag, ".imem_addr"}, imem_addr, e_pc);
        check({tag, ".instr"}, if_id_instr, e_instr);
        check({tag, ".pc4"}, if_id_pc4, e_pc4);
        check({tag, ".valid"}, {31'h0, if_id_valid}, {31'h0, e_valid});
        check({tag, ".addr_err"}, {31'h0, addr_err}, {31'h0, e_err});
    endtask

    task automatic idle_inputs();
        stall = 0; flush = 0; branch_taken = 0; jump = 0;
        branch_target = 32'h0; jump_target = 32'h0;
    endtask

    initial begin
        rst = 0;
        idle_inputs();

        // Reset state
        step();
        check_all("reset", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);

        // Free run from RESET_PC
        rst = 1;
        step(); check_all("run1", 32'h4,  32'h1357_0000, 32'h4,  1'b1, 1'b0);
        step(); check_all("run2", 32'h8,  32'h1357_0004, 32'h8,  1'b1, 1'b0);
        step(); check_all("run3", 32'hC,  32'h1357_0008, 32'hC,  1'b1, 1'b0);
        step(); check_all("run4", 32'h10, 32'h1357_000C, 32'h10, 1'b1, 1'b0);

        // Stall two cycles at 0x10, then release
        stall = 1;
        step(); check_all("stall1", 32'h10, 32'h1357_000C, 32'h10, 1'b1, 1'b0);
        step(); check_all("stall2", 32'h10, 32'h1357_000C, 32'h10, 1'b1, 1'b0);
        stall = 0;
        step(); check_all("unstall", 32'h14, 32'h1357_0010, 32'h14, 1'b1, 1'b0);

        // Jump to 0x20, then branch+jump+stall: branch wins
        jump = 1; jump_target = 32'h20;
        step(); check_all("jmp20", 32'h20, 32'h0, 32'h0, 1'b0, 1'b0);
        branch_taken = 1; branch_target = 32'h100;
        jump = 1; jump_target = 32'h200; stall = 1;
        step(); check_all("br_pri", 32'h100, 32'h0, 32'h0, 1'b0, 1'b0);
        idle_inputs();

        // Wrap at top of address space
        jump = 1; jump_target = 32'hFFFF_FFFC;
        step(); check_all("jmp_top", 32'hFFFF_FFFC, 32'h0, 32'h0, 1'b0, 1'b0);
        jump = 0;
        step(); check_all("wrap", 32'h0, 32'hECA8_FFFC, 32'h0, 1'b1, 1'b0);

        // Flush alone: PC advances, bubble in IF/ID
        flush = 1;
        step(); check_all("flush", 32'h4, 32'h0, 32'h0, 1'b0, 1'b0);
        flush = 0;

        // Reach 0x40 with a live instruction, then flush+stall
        jump = 1; jump_target = 32'h3C;
        step(); check_all("jmp3c", 32'h3C, 32'h0, 32'h0, 1'b0, 1'b0);
        jump = 0;
        step(); check_all("at40", 32'h40, 32'h1357_003C, 32'h40, 1'b1, 1'b0);
        flush = 1; stall = 1;
        step(); check_all("flush_stall", 32'h40, 32'h0, 32'h0, 1'b0, 1'b0);
        flush = 0;

        // Reset during a stall
        rst = 0;
        step(); check_all("rst_stall", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
        rst = 1; stall = 0;
        step(); check_all("post_rst", 32'h4, 32'h1357_0000, 32'h4, 1'b1, 1'b0);

        // Misaligned jump target
        jump = 1; jump_target = 32'h102;
        step();
`ifdef FETCH_ALIGN_CHECK_EN
        check_all("misal", 32'h4, 32'h0, 32'h0, 1'b0, 1'b1);
        jump = 0;
        step(); check_all("misal_sticky", 32'h4, 32'h0, 32'h0, 1'b0, 1'b1);
        rst = 0;
        step(); check_all("misal_rst", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
        rst = 1;
        step(); check_all("misal_run", 32'h4, 32'h1357_0000, 32'h4, 1'b1, 1'b0);
`else
        check_all("misal", 32'h100, 32'h0, 32'h0, 1'b0, 1'b0);
        jump = 0;
        step(); check_all("misal_next", 32'h104, 32'h1357_0100, 32'h104, 1'b1, 1'b0);
`endif

        // Reset overrides a redirect
        rst = 0; branch_taken = 1; branch_target = 32'h300; jump = 1; jump_target = 32'h400;
        step(); check_all("rst_redir", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
        idle_inputs(); rst = 1;
        step(); check_all("final", 32'h4, 32'h1357_0000, 32'h4, 1'b1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
